sfi_ea_packer: RTL and testbench
================================

// Module: sfi_ea_packer
// PURPOSE
//  Upstream feeder of the SFI masking stage. Accepts a decoded MIPS instruction plus its
//  base-register value, computes the store effective address (EA = rs + sext(imm16)),
//  and emits the 64-bit SFI word {ea[31:0], instr[31:0]} that the SFI stage consumes.
//  Valid/ready handshake on both sides, 2-entry skid buffer, running store counter.
// PARAMETERS
//  CNT_W     16   width of store_cnt statistic counter
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   reset, asynchronous, active-high
//  in_valid     in   1   upstream beat valid
//  in_ready     out  1   stage can accept a beat
//  in_instr     in   32  MIPS instruction word
//  in_rs_val    in   32  value of register rs (instr[25:21])
//  out_valid    out  1   out_word valid
//  out_ready    in   1   SFI stage accepts
//  out_word     out  64  {ea, instr} to SFI stage ri
//  out_is_store out  1   beat is a store opcode
//  store_cnt    out  CNT_W  number of store beats handed off (out_valid&out_ready)
// BEHAVIOUR
//  - Reset (async, immediate): out_valid=0, out_word=0, out_is_store=0, store_cnt=0,
//    both buffer entries empty; in_ready=1 from the first edge after rst deasserts.
//  - Store opcodes (instr[31:26]): 0x28 SB,0x29 SH,0x2A SWL,0x2B SW,0x2C SDL,0x2D SDR,
//    0x2E SWR,0x38 SC,0x3C SCD,0x3F SD. All others are non-store.
//  - Store: ea = in_rs_val + {{16{imm[15]}},imm[15:0]}, 32-bit modulo (wraps, no flag).
//    Non-store: upper 32 bits = 32'h0; instr passes unchanged in low 32 bits.
//  - Transfer on in_valid&in_ready (input) / out_valid&out_ready (output).
//  - Latency: 1 cycle; beat accepted at edge N is on out_word after edge N.
//  - Buffer: main reg (drives outputs) + skid reg. in_ready = ~skid_full (registered
//    state, no comb path from out_ready). Accept while main busy & !out_ready -> skid.
//    On output transfer, skid moves to main same edge; simultaneous accept+emit with
//    empty skid -> new beat loads main directly. Full throughput 1 beat/cycle.
//  - out_word/out_is_store held stable while out_valid & !out_ready. Strict FIFO order.
//  - store_cnt increments on output transfer with out_is_store=1; saturates at all-ones.
//  - rst mid-stream: all buffered beats discarded, counter cleared; no partial beat out.
// CONFIGURATION
//  SFI_ALIGN_CHK_EN defined: adds port out_misalign (out,1), registered with the beat;
//    =1 when store EA misaligned: SH ea[0]!=0; SW/SC ea[1:0]!=0; SD/SCD ea[2:0]!=0;
//    SB/SWL/SWR/SDL/SDR never. Beat still forwarded unchanged. Reset 0.
//  Undefined: port absent, no alignment logic.
// STRUCTURE
//  - Shared include sfi_defs.vh: SFI_WORD_W=64, INSTR_W=32, opcode localparams above,
//    is-store function; also used by the SFI stage.
//  - One sub-module: sfi_skid_buf (2-entry valid/ready skid, data width param).
//  - Top holds decode + EA adder + counter.
// TESTING
//  - instr A0A10010, rs FAFA0000 -> out_word FAFA0010_A0A10010, out_is_store=1, cnt=1.
//  - instr AC22FFFC (SW, -4), rs 00001000 -> out_word 00000FFC_AC22FFFC.
//  - instr 00432820 (ADD), rs 12345678 -> out_word 00000000_00432820, is_store=0.
//  - SB imm 0002, rs FFFFFFFF -> ea 00000001 (wrap), no error.
//  - out_ready=0 for 3 cycles, 3 beats offered -> 2 accepted, in_ready=0; release ->
//    beats emerge in order, 1/cycle, third accepted the cycle after in_ready=1.
//  - rst pulse with 2 beats buffered -> out_valid=0, store_cnt=0 immediately;
//    ALIGN_EN build: SW rs 00000002 imm 0 -> out_misalign=1.

Source files
------------

// File: rtl/sfi_ea_packer_pkg.sv
// sfi_ea_packer_pkg
//   Shared definitions for the SFI front end: word widths, MIPS store opcodes,
//   the store-opcode decode and the store alignment rule.
//   The beat record carried through the skid buffer is defined here as well.
//   Build option: SFI_ALIGN_CHK_EN adds a misalign flag to the beat record.
package sfi_ea_packer_pkg;

    localparam int SFI_WORD_W = 64;
    localparam int INSTR_W    = 32;

    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SWL = 6'h2A;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_SDL = 6'h2C;
    localparam logic [5:0] OP_SDR = 6'h2D;
    localparam logic [5:0] OP_SWR = 6'h2E;
    localparam logic [5:0] OP_SC  = 6'h38;
    localparam logic [5:0] OP_SCD = 6'h3C;
    localparam logic [5:0] OP_SD  = 6'h3F;

    // One beat as it sits in the buffer; word/is_store drive the outputs directly.
    typedef struct packed {
`ifdef SFI_ALIGN_CHK_EN
        logic                  misalign;
`endif
        logic                  is_store;
        logic [SFI_WORD_W-1:0] word;
    } sfi_beat_t;

    function automatic logic is_store_op(input logic [5:0] op);
        case (op)
            OP_SB, OP_SH, OP_SWL, OP_SW, OP_SDL,
            OP_SDR, OP_SWR, OP_SC, OP_SCD, OP_SD: is_store_op = 1'b1;
            default:                               is_store_op = 1'b0;
        endcase
    endfunction

    // Natural-size stores must be aligned; the unaligned-access forms
    // (SWL/SWR/SDL/SDR) and byte stores never flag.
    function automatic logic store_misaligned(input logic [5:0] op, input logic [2:0] ea_lo);
        case (op)
            OP_SH:        store_misaligned = ea_lo[0];
            OP_SW, OP_SC: store_misaligned = |ea_lo[1:0];
            OP_SD, OP_SCD: store_misaligned = |ea_lo[2:0];
            default:      store_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sfi_skid_buf.sv
// sfi_skid_buf
//   Two-entry valid/ready skid buffer. The main register drives the outputs,
//   the skid register absorbs one beat arriving while the output is stalled.
//   in_ready_o is purely registered state: no combinational path from out_ready_i.
// Ports
//   clk, rst          clock, async active-high reset
//   in_valid_i/in_ready_o/in_data_i     upstream side
//   out_valid_o/out_ready_i/out_data_o  downstream side
module sfi_skid_buf #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o
);

    logic          main_vld_q, main_vld_d;
    logic          skid_vld_q, skid_vld_d;
    logic [DW-1:0] main_q, main_d;
    logic [DW-1:0] skid_q, skid_d;
    logic          en_q;   // holds ready low until the first edge after reset
    logic          acc, emit;

    assign in_ready_o  = en_q & ~skid_vld_q;
    assign out_valid_o = main_vld_q;
    assign out_data_o  = main_q;

    assign acc  = in_valid_i & in_ready_o;
    assign emit = main_vld_q & out_ready_i;

    always_comb begin
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        main_d     = main_q;
        skid_d     = skid_q;
        if (emit) begin
            if (skid_vld_q) begin
                // skid full means acc is 0 this cycle; oldest pending beat moves up
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end else begin
                main_vld_d = acc;
                if (acc) main_d = in_data_i;
            end
        end else if (acc) begin
            if (!main_vld_q) begin
                main_vld_d = 1'b1;
                main_d     = in_data_i;
            end else begin
                skid_vld_d = 1'b1;
                skid_d     = in_data_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q       <= 1'b0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            en_q       <= 1'b1;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

endmodule

// File: rtl/sfi_ea_packer.sv
// sfi_ea_packer
//   Front end of the SFI masking stage. Decodes store opcodes, computes the
//   store effective address rs + sext(imm16) and packs {ea, instr} into the
//   64-bit SFI word. Non-stores carry a zero upper half. One cycle latency
//   through a 2-entry skid buffer; counts store beats handed downstream.
// Ports
//   clk, rst                      clock, async active-high reset
//   in_valid/in_ready             upstream handshake
//   in_instr, in_rs_val           instruction word and value of rs
//   out_valid/out_ready           downstream handshake
//   out_word, out_is_store        packed SFI word and store flag
//   store_cnt                     saturating count of store beats handed off
//   out_misalign                  (only with SFI_ALIGN_CHK_EN) store EA misaligned
// Build option: SFI_ALIGN_CHK_EN
module sfi_ea_packer
    import sfi_ea_packer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INSTR_W-1:0]    in_instr,
    input  logic [31:0]           in_rs_val,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SFI_WORD_W-1:0] out_word,
    output logic                  out_is_store,
`ifdef SFI_ALIGN_CHK_EN
    output logic                  out_misalign,
`endif
    output logic [CNT_W-1:0]      store_cnt
);

    logic [5:0]  op;
    logic [31:0] ea;
    sfi_beat_t   beat_in, beat_out;
    logic        store_cnt_inc;
    logic [CNT_W-1:0] store_cnt_q, store_cnt_d;

    assign op = in_instr[31:26];
    assign ea = in_rs_val + {{16{in_instr[15]}}, in_instr[15:0]};

    always_comb begin
        beat_in          = '0;
        beat_in.is_store = is_store_op(op);
        beat_in.word     = beat_in.is_store ? {ea, in_instr} : {32'h0, in_instr};
`ifdef SFI_ALIGN_CHK_EN
        beat_in.misalign = store_misaligned(op, ea[2:0]);
`endif
    end

    sfi_skid_buf #(
        .DW($bits(sfi_beat_t))
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (beat_in),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (beat_out)
    );

    assign out_word     = beat_out.word;
    assign out_is_store = beat_out.is_store;
`ifdef SFI_ALIGN_CHK_EN
    assign out_misalign = beat_out.misalign;
`endif

    // Saturating: stops at all-ones rather than wrapping.
    assign store_cnt_inc = out_valid & out_ready & beat_out.is_store & ~(&store_cnt_q);
    assign store_cnt_d   = store_cnt_inc ? store_cnt_q + 1'b1 : store_cnt_q;
    assign store_cnt     = store_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) store_cnt_q <= '0;
        else     store_cnt_q <= store_cnt_d;
    end

endmodule

// File: tb/tb_sfi_ea_packer.sv
module tb_sfi_ea_packer;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_rs_val = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_word;
    logic        out_is_store;
    logic [CNT_W-1:0] store_cnt;
`ifdef SFI_ALIGN_CHK_EN
    logic        out_misalign;
`endif

    always #5 clk = ~clk;

    sfi_ea_packer #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_rs_val   (in_rs_val),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_word    (out_word),
        .out_is_store(out_is_store),
`ifdef SFI_ALIGN_CHK_EN
        .out_misalign(out_misalign),
`endif
        .store_cnt   (store_cnt)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: a FIFO of expected beats {is_store, word[63:0]} plus counter.
    logic [64:0]      q[$];
    logic [CNT_W-1:0] m_cnt = '0;

    function automatic logic [64:0] ref_beat(input logic [31:0] instr, input logic [31:0] rs);
        logic [5:0]  op;
        logic [31:0] ea;
        op = instr[31:26];
        ea = 32'(rs + 32'(int'($signed(instr[15:0]))));
        if (op inside {6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2C, 6'h2D, 6'h2E, 6'h38, 6'h3C, 6'h3F})
            return {1'b1, ea, instr};
        return {1'b0, 32'h0, instr};
    endfunction

    // Called at a negedge: apply inputs, clock one edge, check at next negedge.
    task automatic step(input logic v, input logic [31:0] instr, input logic [31:0] rs,
                        input logic ordy);
        bit acc, emit;
        in_valid  = v;
        in_instr  = instr;
        in_rs_val = rs;
        out_ready = ordy;
        acc  = v && (q.size() < 2);
        emit = ordy && (q.size() > 0);
        @(posedge clk);
        if (emit) begin
            if (q[0][64] && m_cnt != CNT_MAX) m_cnt++;
            void'(q.pop_front());
        end
        if (acc) q.push_back(ref_beat(instr, rs));
        @(negedge clk);
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        chk("store_cnt", 64'(store_cnt), 64'(m_cnt));
        if (q.size() > 0) begin
            chk("out_word", out_word, q[0][63:0]);
            chk("out_is_store", 64'(out_is_store), 64'(q[0][64]));
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops[10] = '{6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2C, 6'h2D, 6'h2E, 6'h38, 6'h3C, 6'h3F};
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 1) == 1) r[31:26] = ops[$urandom_range(0, 9)];
        return r;
    endfunction

    logic [31:0] b0, b1, b2;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_word", out_word, 64'd0);
        chk("rst_is_store", 64'(out_is_store), 64'd0);
        chk("rst_cnt", 64'(store_cnt), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Spec vectors
        step(1, 32'hA0A10010, 32'hFAFA0000, 1);
        chk("sb_word", out_word, 64'hFAFA0010_A0A10010);
        chk("sb_is_store", 64'(out_is_store), 64'd1);
        step(1, 32'hAC22FFFC, 32'h00001000, 1);
        chk("sb_cnt", 64'(store_cnt), 64'd1);
        chk("sw_word", out_word, 64'h00000FFC_AC22FFFC);
        step(1, 32'h00432820, 32'h12345678, 1);
        chk("add_word", out_word, 64'h00000000_00432820);
        chk("add_is_store", 64'(out_is_store), 64'd0);
        step(1, 32'hA0000002, 32'hFFFFFFFF, 1);
        chk("sb_wrap", out_word, 64'h00000001_A0000002);
        step(0, 32'h0, 32'h0, 1);
        chk("cnt_after4", 64'(store_cnt), 64'd3);

        // Backpressure: 3 beats offered while stalled, only 2 fit
        b0 = 32'hAC000000; b1 = 32'hAC000004; b2 = 32'h00000008;
        step(1, b0, 32'h100, 0);
        step(1, b1, 32'h100, 0);
        step(1, b2, 32'h100, 0);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_head", out_word, 64'h00000100_AC000000);
        step(1, b2, 32'h100, 1);
        chk("bp_second", out_word, 64'h00000104_AC000004);
        chk("bp_ready_back", 64'(in_ready), 64'd1);
        step(1, b2, 32'h100, 1);
        chk("bp_third", out_word, 64'h00000000_00000008);
        step(0, 32'h0, 32'h0, 1);
        chk("bp_drained", 64'(out_valid), 64'd0);

        // Reset with two beats buffered and a nonzero counter
        step(1, b0, 32'h0, 0);
        step(1, b1, 32'h0, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_cnt", 64'(store_cnt), 64'd0);
        q.delete();
        m_cnt = '0;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", 64'(out_valid), 64'd0);
        chk("post_rst_ready", 64'(in_ready), 64'd1);

        // Randomized traffic; long enough for the counter to saturate
        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 3) != 0), rand_instr(), $urandom,
                 ($urandom_range(0, 2) != 0));
        chk("cnt_saturated", 64'(store_cnt), 64'(CNT_MAX));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
